// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
//  Shared definitions for the rysy writeback stage:
//   - default data width
//   - write-back source select codes (wb_sel)
//   - load type codes (load_type)
//   - writeback FSM state encoding
//   - load alignment check helper
//  No ports (package).
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int REG_LEN_DEF = 32;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    // Load types (funct3 encoding of the RISC-V loads)
    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    // Halfwords may sit at offsets 0..2 inside the fetched word (the memory
    // returns the whole aligned word, so only a halfword straddling the word
    // boundary is unreachable). Unknown load codes are treated like LW.
    function automatic logic load_misaligned(input logic [2:0] lt,
                                             input logic [1:0] off);
        logic res;
        res = 1'b0;
        case (lt)
            LD_LB, LD_LBU: res = 1'b0;
            LD_LH, LD_LHU: res = (off == 2'd3);
            default:       res = (off != 2'd0);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// ---------------------------------------------------------------------------
// wb_stage_load_align
//  Combinational load data alignment: picks the addressed byte / halfword out
//  of the raw aligned memory word and sign- or zero-extends it to REG_LEN.
//  Ports:
//   i_mem_rdata  in  REG_LEN  raw aligned word from data memory
//   i_off        in  2        byte offset of the load (address[1:0])
//   i_load_type  in  3        LB/LH/LW/LBU/LHU code
//   o_load_val   out REG_LEN  aligned, extended write-back value
// ---------------------------------------------------------------------------
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int REG_LEN = REG_LEN_DEF
) (
    input  logic [REG_LEN-1:0] i_mem_rdata,
    input  logic [1:0]         i_off,
    input  logic [2:0]         i_load_type,
    output logic [REG_LEN-1:0] o_load_val
);

    logic [7:0]  w_bytes  [4];
    logic [15:0] w_halves [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bytes[gi] = i_mem_rdata[8*gi +: 8];
            if (gi < 3) begin : g_half
                assign w_halves[gi] = i_mem_rdata[8*gi +: 16];
            end else begin : g_half_top
                // Offset 3 halfword is rejected as misaligned; lane only
                // exists so the index below is always in range.
                assign w_halves[gi] = {8'h00, i_mem_rdata[31:24]};
            end
        end
    endgenerate

    assign w_byte = w_bytes[i_off];
    assign w_half = w_halves[i_off];

    always_comb begin
        o_load_val = i_mem_rdata;
        case (i_load_type)
            LD_LB:   o_load_val = {{(REG_LEN-8){w_byte[7]}}, w_byte};
            LD_LBU:  o_load_val = {{(REG_LEN-8){1'b0}}, w_byte};
            LD_LH:   o_load_val = {{(REG_LEN-16){w_half[15]}}, w_half};
            LD_LHU:  o_load_val = {{(REG_LEN-16){1'b0}}, w_half};
            default: o_load_val = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//  Writeback stage of the rysy core. Accepts finished results from execute,
//  selects the write value (ALU, PC+4, immediate or aligned load data) and
//  drives the register file write port. Loads wait in WAIT_MEM for mem_valid
//  with a MEM_TIMEOUT cycle limit.
//  Optional feature macro: WB_FWD_EN -- exposes the pending write on fwd_*.
//  Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        handshake from execute
//   rd_addr, wb_sel            destination and write-back source
//   alu_out, pc, imm           candidate values (alu_out = address for loads)
//   load_type                  load width / signedness
//   mem_rdata, mem_valid       load data return
//   rf_we, rf_waddr, rf_wdata  register file write port (one-cycle pulse)
//   stall                      freeze upstream while waiting for memory
//   err_align, err_timeout     one-cycle error pulses
//   fwd_valid/addr/data        pending write (WB_FWD_EN only)
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int REG_LEN     = REG_LEN_DEF,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         rd_addr,
    input  logic [1:0]         wb_sel,
    input  logic [REG_LEN-1:0] alu_out,
    input  logic [REG_LEN-1:0] pc,
    input  logic [REG_LEN-1:0] imm,
    input  logic [2:0]         load_type,
    input  logic [REG_LEN-1:0] mem_rdata,
    input  logic               mem_valid,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [REG_LEN-1:0] rf_wdata,
    output logic               stall,
    output logic               err_align,
`ifdef WB_FWD_EN
    output logic               err_timeout,
    output logic               fwd_valid,
    output logic [4:0]         fwd_addr,
    output logic [REG_LEN-1:0] fwd_data
`else
    output logic               err_timeout
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    wb_state_e          r_state;
    logic [4:0]         r_ld_rd;
    logic [2:0]         r_ld_type;
    logic [1:0]         r_ld_off;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rf_we;
    logic [4:0]         r_rf_waddr;
    logic [REG_LEN-1:0] r_rf_wdata;
    logic               r_err_align;
    logic               r_err_timeout;

    logic [REG_LEN-1:0] w_result;
    logic [REG_LEN-1:0] w_load_val;
    logic               w_misaligned;
    logic [CNT_W-1:0]   w_cnt_next;

    // Non-load write value; pc+4 wraps naturally at REG_LEN bits.
    always_comb begin
        w_result = alu_out;
        case (wb_sel)
            WB_PC4:  w_result = pc + REG_LEN'(4);
            WB_IMM:  w_result = imm;
            default: w_result = alu_out;
        endcase
    end

    assign w_misaligned = load_misaligned(load_type, alu_out[1:0]);

    // r_cnt holds completed WAIT_MEM cycles; w_cnt_next includes the current
    // one, so the timeout pulse lands exactly MEM_TIMEOUT cycles after entry.
    assign w_cnt_next = r_cnt + 1'b1;

    wb_stage_load_align #(
        .REG_LEN(REG_LEN)
    ) u_load_align (
        .i_mem_rdata(mem_rdata),
        .i_off      (r_ld_off),
        .i_load_type(r_ld_type),
        .o_load_val (w_load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ld_rd       <= '0;
            r_ld_type     <= '0;
            r_ld_off      <= '0;
            r_cnt         <= '0;
            r_rf_we       <= 1'b0;
            r_rf_waddr    <= '0;
            r_rf_wdata    <= '0;
            r_err_align   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            r_rf_we       <= 1'b0;
            r_err_align   <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    if (in_valid) begin
                        if (wb_sel != WB_MEM) begin
                            r_rf_waddr <= rd_addr;
                            r_rf_wdata <= w_result;
                            r_rf_we    <= (rd_addr != 5'd0);
                            r_state    <= ST_WRITE;
                        end else begin
                            r_ld_rd   <= rd_addr;
                            r_ld_type <= load_type;
                            r_ld_off  <= alu_out[1:0];
                            r_cnt     <= '0;
                            if (w_misaligned) begin
                                r_err_align <= 1'b1;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_state <= ST_WAIT_MEM;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_MEM: begin
                    r_cnt <= w_cnt_next;
                    // mem_valid takes priority over the timeout check.
                    if (mem_valid) begin
                        r_rf_waddr <= r_ld_rd;
                        r_rf_wdata <= w_load_val;
                        r_rf_we    <= (r_ld_rd != 5'd0);
                        r_state    <= ST_WRITE;
                    end else if (w_cnt_next == CNT_LIMIT) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state != ST_WAIT_MEM);
    assign stall       = (r_state == ST_WAIT_MEM);
    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign err_align   = r_err_align;
    assign err_timeout = r_err_timeout;

`ifdef WB_FWD_EN
    // rf_we is never high in WAIT_MEM, so fwd_valid is low there as well.
    assign fwd_valid = r_rf_we;
    assign fwd_addr  = r_rf_waddr;
    assign fwd_data  = r_rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//  Self-checking bench for wb_stage: directed and randomized ALU/PC4/IMM
//  writes and loads against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    localparam int RL = 32;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    rd_addr;
    logic [1:0]    wb_sel;
    logic [RL-1:0] alu_out;
    logic [RL-1:0] pc;
    logic [RL-1:0] imm;
    logic [2:0]    load_type;
    logic [RL-1:0] mem_rdata;
    logic          mem_valid;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [RL-1:0] rf_wdata;
    logic          stall;
    logic          err_align;
    logic          err_timeout;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [4:0]    fwd_addr;
    logic [RL-1:0] fwd_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    wb_stage #(.REG_LEN(RL), .MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .wb_sel     (wb_sel),
        .alu_out    (alu_out),
        .pc         (pc),
        .imm        (imm),
        .load_type  (load_type),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall      (stall),
        .err_align  (err_align),
`ifdef WB_FWD_EN
        .err_timeout(err_timeout),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data)
`else
        .err_timeout(err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_value(input int sel, input logic [31:0] a,
                                              input logic [31:0] p, input logic [31:0] i);
        longint unsigned s;
        if (sel == 2) begin
            s = (longint'(p) + 4) % (64'd1 << 32);
            return s[31:0];
        end
        if (sel == 3) return i;
        return a;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int lt);
        int unsigned v;
        v = w / (32'd1 << (8 * off));
        case (lt)
            0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            4: v = v % 256;
            1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            5: v = v % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit ref_misaligned(input int lt, input int off);
        if (lt == 2) return off != 0;
        if (lt == 1 || lt == 5) return off == 3;
        return 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid  = 1'b0;
        mem_valid = 1'b0;
        rd_addr   = 5'($urandom);
        wb_sel    = 2'($urandom);
        alu_out   = $urandom;
        pc        = $urandom;
        imm       = $urandom;
        load_type = 3'($urandom);
        mem_rdata = $urandom;
    endtask

    // One ALU/PC4/IMM transaction, then one idle cycle.
    task automatic do_alu(input int sel, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] p, input logic [31:0] i);
        logic [31:0] exp;
        exp = ref_value(sel, a, p, i);
        in_valid = 1'b1; wb_sel = 2'(sel); rd_addr = rd; alu_out = a; pc = p; imm = i;
        tick();
        set_idle();
        $display("txn alu sel=%0d rd=%0d value=%08h we=%0d", sel, rd, exp, rf_we);
        n_vec++;
        if (rf_we !== (rd != 0)) begin
            n_err++;
            $display("FAIL alu_we: got %0d, required %0d", rf_we, (rd != 0));
        end
        if (rd != 0) begin
            n_vec++;
            if ({rf_waddr, rf_wdata} !== {rd, exp}) begin
                n_err++;
                $display("FAIL alu_data: got addr=%0d data=%08h, required addr=%0d data=%08h",
                         rf_waddr, rf_wdata, rd, exp);
            end
        end
`ifdef WB_FWD_EN
        n_vec++;
        if (fwd_valid !== (rd != 0) || (rd != 0 && {fwd_addr, fwd_data} !== {rd, exp})) begin
            n_err++;
            $display("FAIL fwd: got v=%0d a=%0d d=%08h, required v=%0d a=%0d d=%08h",
                     fwd_valid, fwd_addr, fwd_data, (rd != 0), rd, exp);
        end
`endif
        tick();
        n_vec++;
        if ({rf_we, stall, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL alu_idle: got we=%0d stall=%0d rdy=%0d, required 0 0 1",
                     rf_we, stall, in_ready);
        end
    endtask

    // One load: delay = cycles in WAIT_MEM before data (1..TO).
    task automatic do_load(input int lt, input int off, input logic [31:0] word,
                           input int delay, input logic [4:0] rd);
        logic [31:0] exp;
        int          stalls;
        exp = ref_load(word, off, lt);
        in_valid = 1'b1; wb_sel = 2'd1; rd_addr = rd; load_type = 3'(lt);
        alu_out = {$urandom} & 32'hFFFF_FFFC | 32'(off);
        tick();
        set_idle();
        if (ref_misaligned(lt, off)) begin
            $display("txn load lt=%0d off=%0d misaligned", lt, off);
            n_vec++;
            if ({err_align, rf_we, stall, in_ready} !== 4'b1001) begin
                n_err++;
                $display("FAIL align_pulse: got err=%0d we=%0d stall=%0d rdy=%0d, required 1 0 0 1",
                         err_align, rf_we, stall, in_ready);
            end
            tick();
            n_vec++;
            if ({err_align, rf_we} !== 2'b00) begin
                n_err++;
                $display("FAIL align_end: got err=%0d we=%0d, required 0 0", err_align, rf_we);
            end
            return;
        end
        stalls = 0;
        for (int k = 0; k < delay; k++) begin
            if (stall === 1'b1 && in_ready === 1'b0 && rf_we === 1'b0) stalls++;
            if (k == delay - 1) begin
                mem_valid = 1'b1;
                mem_rdata = word;
            end
            tick();
        end
        set_idle();
        $display("txn load lt=%0d off=%0d rd=%0d word=%08h delay=%0d value=%08h",
                 lt, off, rd, word, delay, exp);
        n_vec++;
        if (stalls != delay) begin
            n_err++;
            $display("FAIL load_stall: got %0d stall cycles, required %0d", stalls, delay);
        end
        n_vec++;
        if ({rf_we, stall, err_timeout} !== {(rd != 5'd0), 2'b00}) begin
            n_err++;
            $display("FAIL load_we: got we=%0d stall=%0d to=%0d, required we=%0d stall=0 to=0",
                     rf_we, stall, err_timeout, (rd != 0));
        end
        if (rd != 0) begin
            n_vec++;
            if ({rf_waddr, rf_wdata} !== {rd, exp}) begin
                n_err++;
                $display("FAIL load_data: got addr=%0d data=%08h, required addr=%0d data=%08h",
                         rf_waddr, rf_wdata, rd, exp);
            end
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        mem_valid = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, stall, in_ready, err_align, err_timeout}
            !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got we=%0d a=%0d d=%08h stall=%0d rdy=%0d ea=%0d et=%0d, required 0 0 0 0 1 0 0",
                     rf_we, rf_waddr, rf_wdata, stall, in_ready, err_align, err_timeout);
        end
        #3 rst_n = 1'b1;
        set_idle();
        tick();
        $display("txn reset released");
    endtask

    task automatic test_alu();
        do_alu(0, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
        do_alu(2, 5'd7, 32'h0, 32'hFFFF_FFFC, 32'h0);   // pc+4 wraps to 0
        do_alu(3, 5'd31, 32'h0, 32'h0, 32'hABCD_E000);
        for (int n = 0; n < 20; n++) begin
            int s;
            s = $urandom_range(0, 2);
            if (s == 1) s = 3;
            do_alu(s, 5'($urandom_range(1, 31)), $urandom, $urandom, $urandom);
        end
    endtask

    task automatic test_load_directed();
        do_load(0, 3, 32'h80FF_FF00, 2, 5'd9);   // LB  -> FFFFFF80
        do_load(4, 3, 32'h80FF_FF00, 2, 5'd9);   // LBU -> 00000080
        do_load(1, 1, 32'h12F0_0F34, 1, 5'd10);  // LH at off 1
        do_load(5, 2, 32'h8001_0000, 3, 5'd11);  // LHU upper half
        do_load(2, 0, 32'hCAFE_F00D, TO, 5'd12); // data on the timeout cycle wins
    endtask

    task automatic test_misalign();
        do_load(2, 2, 32'h1111_1111, 1, 5'd4);   // LW off 2
        do_load(1, 3, 32'h2222_2222, 1, 5'd4);   // LH off 3
        do_load(5, 3, 32'h3333_3333, 1, 5'd4);   // LHU off 3
    endtask

    task automatic test_timeout();
        int stalls;
        in_valid = 1'b1; wb_sel = 2'd1; rd_addr = 5'd6; load_type = 3'd2; alu_out = 32'h100;
        tick();
        set_idle();
        stalls = 0;
        for (int k = 0; k < TO; k++) begin
            if (stall === 1'b1 && err_timeout === 1'b0) stalls++;
            tick();
        end
        $display("txn timeout load rd=6 stall_cycles=%0d", stalls);
        n_vec++;
        if (stalls != TO) begin
            n_err++;
            $display("FAIL timeout_wait: got %0d cycles, required %0d", stalls, TO);
        end
        n_vec++;
        if ({err_timeout, rf_we, stall, in_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL timeout_pulse: got et=%0d we=%0d stall=%0d rdy=%0d, required 1 0 0 1",
                     err_timeout, rf_we, stall, in_ready);
        end
        mem_valid = 1'b1;   // late data must be ignored
        tick();
        mem_valid = 1'b0;
        n_vec++;
        if ({err_timeout, rf_we} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_end: got et=%0d we=%0d, required 0 0", err_timeout, rf_we);
        end
    endtask

    task automatic test_rd0();
        do_alu(0, 5'd0, 32'h0000_DEAD, 32'h0, 32'h0);
        do_load(2, 0, 32'h5555_AAAA, 3, 5'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int r = 1; r <= 3; r++) begin
            v = $urandom;
            in_valid = 1'b1; wb_sel = 2'd0; rd_addr = 5'(r); alu_out = v;
            tick();
            $display("txn b2b rd=%0d value=%08h", r, v);
            n_vec++;
            if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'(r), v, 1'b1}) begin
                n_err++;
                $display("FAIL b2b: got we=%0d a=%0d d=%08h rdy=%0d, required 1 %0d %08h 1",
                         rf_we, rf_waddr, rf_wdata, in_ready, r, v);
            end
        end
        set_idle();
        tick();
        n_vec++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got we=%0d, required 0", rf_we);
        end
    endtask

    task automatic test_random_loads();
        int lts [5] = '{0, 1, 2, 4, 5};
        for (int n = 0; n < 30; n++) begin
            do_load(lts[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom,
                    $urandom_range(1, TO), 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_reset_mid_load();
        in_valid = 1'b1; wb_sel = 2'd1; rd_addr = 5'd8; load_type = 3'd2; alu_out = 32'h40;
        tick();
        set_idle();
        tick();
        rst_n = 1'b0;
        #1;
        $display("txn reset during WAIT_MEM");
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, stall, in_ready, err_align, err_timeout}
            !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got we=%0d a=%0d d=%08h stall=%0d rdy=%0d ea=%0d et=%0d, required 0 0 0 0 1 0 0",
                     rf_we, rf_waddr, rf_wdata, stall, in_ready, err_align, err_timeout);
        end
        #2 rst_n = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        tick();
        mem_valid = 1'b0;
        n_vec++;
        if ({rf_we, stall, err_timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset_late: got we=%0d stall=%0d et=%0d, required 0 0 0",
                     rf_we, stall, err_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_directed();
        test_misalign();
        test_timeout();
        test_rd0();
        test_back_to_back();
        test_random_loads();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
